top_vector_driver: RTL and testbench

- Sequential stimulus/response stage sitting directly upstream and downstream of the merged-pin `top` block.
- Accepts 2-bit input vectors over a valid/ready handshake and drives them onto `top.in1` / `top.in2`.
- Waits a programmable settle time, then samples `top.out1` and compares it with an expected value.
- Returns the result over a second valid/ready handshake and keeps a saturating mismatch counter for pin-merge regression runs.

---
 rtl/top_vector_driver.sv | 154 +++++++++++++++
 tb/tb_top_vector_driver.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_vector_driver.sv
// top_vector_driver
// Stimulus/response stage wrapped around the merged-pin `top` block. A 2-bit
// vector accepted over a valid/ready handshake is driven onto top.in1/in2,
// held for SETTLE_CYCLES edges, then top.out1 is sampled, compared with the
// vector's expected value and returned over a second valid/ready handshake.
// A saturating counter accumulates mismatches across a regression run.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   vec_valid/vec_ready             stimulus handshake
//   vec_data[1:0], vec_expect       stimulus (bit0 -> in1, bit1 -> in2), expected out1
//   drive_in1, drive_in2            registered drives to top.in1 / top.in2
//   sense_out1                      top.out1, same clock domain
//   res_valid/res_ready             result handshake
//   res_data, res_vec, res_mismatch sampled out1, echoed vector, out1 ^ expect
//   err_cnt[ERR_W-1:0], err_clr     saturating mismatch count, synchronous clear
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for a vector; drives hold the previous vector
// SETTLE | drives stable, counting down to the out1 sample edge
// HOLD   | result presented, waiting for res_ready

module top_vector_driver #(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [1:0]       vec_data,
    input  logic             vec_expect,
    output logic             drive_in1,
    output logic             drive_in2,
    input  logic             sense_out1,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_data,
    output logic [1:0]       res_vec,
    output logic             res_mismatch,
    output logic [ERR_W-1:0] err_cnt,
    input  logic             err_clr
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("top_vector_driver: SETTLE_CYCLES must be in 1..255");
    end

    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] settle_cnt;
    logic [1:0] vec_lat;
    logic       expect_lat;
    logic       accept;
    logic       sample;
    logic       release_res;
    logic       mismatch_now;

    assign mismatch_now = sense_out1 ^ expect_lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        vec_ready   = 1'b0;
        accept      = 1'b0;
        sample      = 1'b0;
        release_res = 1'b0;
        case (state)
            IDLE: begin
                vec_ready = 1'b1;
                if (vec_valid) begin
                    accept    = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                // Terminal count: this edge is E0 + SETTLE_CYCLES.
                if (settle_cnt == 8'd0) begin
                    sample    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    release_res = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drive_in1    <= 1'b0;
            drive_in2    <= 1'b0;
            vec_lat      <= 2'b00;
            expect_lat   <= 1'b0;
            settle_cnt   <= 8'd0;
            res_valid    <= 1'b0;
            res_data     <= 1'b0;
            res_vec      <= 2'b00;
            res_mismatch <= 1'b0;
        end else begin
            if (accept) begin
                drive_in1  <= vec_data[0];
                drive_in2  <= vec_data[1];
                vec_lat    <= vec_data;
                expect_lat <= vec_expect;
                settle_cnt <= SETTLE_LOAD;
            end else if (state == SETTLE && !sample) begin
                settle_cnt <= settle_cnt - 8'd1;
            end

            if (sample) begin
                res_data     <= sense_out1;
                res_vec      <= vec_lat;
                res_mismatch <= mismatch_now;
                res_valid    <= 1'b1;
            end else if (release_res) begin
                res_valid <= 1'b0;
            end
        end
    end

    // Clear has priority over a coincident mismatch increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (sample && mismatch_now && err_cnt != ERR_MAX) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_top_vector_driver.sv
module tb_top_vector_driver;

    localparam int SA = 4;
    localparam int SB = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int m_err_a = 0;
    int m_err_b = 0;

    // Instance A: SETTLE_CYCLES = 4, ERR_W = 8
    logic       a_vec_valid, a_vec_ready, a_vec_expect;
    logic [1:0] a_vec_data;
    logic       a_drive_in1, a_drive_in2, a_sense;
    logic       a_res_valid, a_res_ready, a_res_data, a_res_mismatch;
    logic [1:0] a_res_vec;
    logic [7:0] a_err_cnt;
    logic       a_err_clr;

    // Instance B: SETTLE_CYCLES = 1, ERR_W = 2
    logic       b_vec_valid, b_vec_ready, b_vec_expect;
    logic [1:0] b_vec_data;
    logic       b_drive_in1, b_drive_in2, b_sense;
    logic       b_res_valid, b_res_ready, b_res_data, b_res_mismatch;
    logic [1:0] b_res_vec;
    logic [1:0] b_err_cnt;
    logic       b_err_clr;

    // Stand-in for the merged-pin block: out1 = in1 | in2.
    assign a_sense = a_drive_in1 | a_drive_in2;
    assign b_sense = b_drive_in1 | b_drive_in2;

    top_vector_driver #(.SETTLE_CYCLES(SA), .ERR_W(8)) u_a (
        .clk(clk), .rst_n(rst_n),
        .vec_valid(a_vec_valid), .vec_ready(a_vec_ready),
        .vec_data(a_vec_data), .vec_expect(a_vec_expect),
        .drive_in1(a_drive_in1), .drive_in2(a_drive_in2),
        .sense_out1(a_sense),
        .res_valid(a_res_valid), .res_ready(a_res_ready),
        .res_data(a_res_data), .res_vec(a_res_vec), .res_mismatch(a_res_mismatch),
        .err_cnt(a_err_cnt), .err_clr(a_err_clr)
    );

    top_vector_driver #(.SETTLE_CYCLES(SB), .ERR_W(2)) u_b (
        .clk(clk), .rst_n(rst_n),
        .vec_valid(b_vec_valid), .vec_ready(b_vec_ready),
        .vec_data(b_vec_data), .vec_expect(b_vec_expect),
        .drive_in1(b_drive_in1), .drive_in2(b_drive_in2),
        .sense_out1(b_sense),
        .res_valid(b_res_valid), .res_ready(b_res_ready),
        .res_data(b_res_data), .res_vec(b_res_vec), .res_mismatch(b_res_mismatch),
        .err_cnt(b_err_cnt), .err_clr(b_err_clr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a_vec_valid = 0; a_vec_data = 0; a_vec_expect = 0; a_res_ready = 0; a_err_clr = 0;
        b_vec_valid = 0; b_vec_data = 0; b_vec_expect = 0; b_res_ready = 0; b_err_clr = 0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({a_drive_in1, a_drive_in2, a_res_valid, a_res_data, a_res_vec, a_res_mismatch} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_a_outputs got %b expected 0000000",
                     {a_drive_in1, a_drive_in2, a_res_valid, a_res_data, a_res_vec, a_res_mismatch});
        end
        n_vec++;
        if (a_err_cnt !== 8'd0 || b_err_cnt !== 2'd0 || b_res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_err_cnt got a=%0d b=%0d b_res_valid=%b expected 0 0 0",
                     a_err_cnt, b_err_cnt, b_res_valid);
        end
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (a_vec_ready !== 1'b1 || b_vec_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_vec_ready got a=%b b=%b expected 1 1", a_vec_ready, b_vec_ready);
        end
        m_err_a = 0;
        m_err_b = 0;
    endtask

    // Ends in HOLD with the result presented; back-pressure test continues from there.
    task automatic test_single_vector;
        a_vec_data = 2'b11; a_vec_expect = 1'b1; a_vec_valid = 1'b1;
        tick();  // E0
        a_vec_valid = 1'b0; a_vec_data = 2'b00; a_vec_expect = 1'b0;
        n_vec++;
        if ({a_drive_in1, a_drive_in2, a_vec_ready, a_res_valid} !== 4'b1100) begin
            n_err++;
            $display("FAIL single_e0 got drv=%b%b ready=%b res_valid=%b expected 11 0 0",
                     a_drive_in2, a_drive_in1, a_vec_ready, a_res_valid);
        end
        for (int k = 1; k < SA; k++) begin
            tick();
            n_vec++;
            if ({a_drive_in1, a_drive_in2, a_vec_ready, a_res_valid} !== 4'b1100) begin
                n_err++;
                $display("FAIL single_settle_e0+%0d got drv=%b%b ready=%b res_valid=%b expected 11 0 0",
                         k, a_drive_in2, a_drive_in1, a_vec_ready, a_res_valid);
            end
        end
        tick();  // E0 + SA
        n_vec++;
        if ({a_res_valid, a_res_data, a_res_vec, a_res_mismatch, a_vec_ready} !== 6'b111100) begin
            n_err++;
            $display("FAIL single_result got valid=%b data=%b vec=%b mism=%b ready=%b expected 1 1 11 0 0",
                     a_res_valid, a_res_data, a_res_vec, a_res_mismatch, a_vec_ready);
        end
        n_vec++;
        if (a_err_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL single_err_cnt got %0d expected 0", a_err_cnt);
        end
    endtask

    task automatic test_back_pressure;
        // A competing vector is offered throughout; it must be ignored until IDLE.
        a_res_ready = 1'b0;
        a_vec_valid = 1'b1; a_vec_data = 2'b00;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_vec++;
            if ({a_res_valid, a_res_data, a_res_vec, a_res_mismatch, a_vec_ready,
                 a_drive_in1, a_drive_in2} !== 8'b11110011) begin
                n_err++;
                $display("FAIL backpressure_hold_%0d got valid=%b data=%b vec=%b mism=%b ready=%b drv=%b%b",
                         k, a_res_valid, a_res_data, a_res_vec, a_res_mismatch, a_vec_ready,
                         a_drive_in2, a_drive_in1);
            end
        end
        a_res_ready = 1'b1;
        tick();
        a_res_ready = 1'b0;
        a_vec_valid = 1'b0;
        n_vec++;
        if ({a_res_valid, a_vec_ready, a_drive_in1, a_drive_in2} !== 4'b0111) begin
            n_err++;
            $display("FAIL backpressure_release got valid=%b ready=%b drv=%b%b expected 0 1 11",
                     a_res_valid, a_vec_ready, a_drive_in2, a_drive_in1);
        end
    endtask

    task automatic run_vec_a(input logic [1:0] v, input logic e, input int bp);
        logic exp_d;
        logic exp_m;
        int   waited;
        exp_d = v[0] | v[1];
        exp_m = exp_d ^ e;
        n_vec++;
        if (a_vec_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rand_a_ready_before got %b expected 1", a_vec_ready);
        end
        a_vec_data = v; a_vec_expect = e; a_vec_valid = 1'b1;
        tick();
        a_vec_valid = 1'b0; a_vec_data = ~v; a_vec_expect = ~e;
        n_vec++;
        if ({a_drive_in2, a_drive_in1} !== v) begin
            n_err++;
            $display("FAIL rand_a_drive got %b%b expected %b", a_drive_in2, a_drive_in1, v);
        end
        repeat (SA - 1) tick();
        n_vec++;
        if (a_res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rand_a_early got res_valid=%b expected 0 at E0+%0d", a_res_valid, SA - 1);
        end
        tick();
        n_vec++;
        if (a_res_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rand_a_latency got res_valid=%b expected 1 at E0+%0d", a_res_valid, SA);
            waited = 0;
            while (a_res_valid !== 1'b1 && waited < 20) begin
                tick();
                waited++;
            end
        end
        if (exp_m && m_err_a < 255) m_err_a++;
        n_vec++;
        if ({a_res_data, a_res_vec, a_res_mismatch} !== {exp_d, v, exp_m} || a_err_cnt !== 8'(m_err_a)) begin
            n_err++;
            $display("FAIL rand_a_result got data=%b vec=%b mism=%b err=%0d expected %b %b %b %0d",
                     a_res_data, a_res_vec, a_res_mismatch, a_err_cnt, exp_d, v, exp_m, m_err_a);
        end
        for (int k = 0; k < bp; k++) begin
            tick();
            n_vec++;
            if ({a_res_valid, a_res_data, a_res_vec, a_res_mismatch} !== {1'b1, exp_d, v, exp_m}) begin
                n_err++;
                $display("FAIL rand_a_stall got valid=%b data=%b vec=%b mism=%b", a_res_valid,
                         a_res_data, a_res_vec, a_res_mismatch);
            end
        end
        a_res_ready = 1'b1;
        tick();
        a_res_ready = 1'b0;
        n_vec++;
        if (a_res_valid !== 1'b0 || a_vec_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rand_a_done got valid=%b ready=%b expected 0 1", a_res_valid, a_vec_ready);
        end
    endtask

    task automatic test_random_a;
        logic [1:0] v;
        logic       e;
        for (int i = 0; i < 20; i++) begin
            v = 2'($urandom_range(3));
            e = 1'($urandom_range(1));
            run_vec_a(v, e, int'($urandom_range(3)));
        end
    endtask

    task automatic run_vec_b(input logic [1:0] v, input logic e, input logic clr_at_sample);
        logic exp_d;
        logic exp_m;
        int   waited;
        exp_d = v[0] | v[1];
        exp_m = exp_d ^ e;
        b_vec_data = v; b_vec_expect = e; b_vec_valid = 1'b1;
        tick();
        b_vec_valid = 1'b0; b_vec_data = ~v; b_vec_expect = ~e;
        n_vec++;
        if ({b_drive_in2, b_drive_in1, b_res_valid} !== {v, 1'b0}) begin
            n_err++;
            $display("FAIL b_drive got drv=%b%b valid=%b expected %b 0", b_drive_in2, b_drive_in1,
                     b_res_valid, v);
        end
        b_err_clr = clr_at_sample;
        tick();
        b_err_clr = 1'b0;
        n_vec++;
        if (b_res_valid !== 1'b1) begin
            n_err++;
            $display("FAIL b_latency got res_valid=%b expected 1 at E0+1", b_res_valid);
            waited = 0;
            while (b_res_valid !== 1'b1 && waited < 20) begin
                tick();
                waited++;
            end
        end
        if (clr_at_sample) m_err_b = 0;
        else if (exp_m && m_err_b < 3) m_err_b++;
        n_vec++;
        if ({b_res_data, b_res_vec, b_res_mismatch} !== {exp_d, v, exp_m} || b_err_cnt !== 2'(m_err_b)) begin
            n_err++;
            $display("FAIL b_result got data=%b vec=%b mism=%b err=%0d expected %b %b %b %0d",
                     b_res_data, b_res_vec, b_res_mismatch, b_err_cnt, exp_d, v, exp_m, m_err_b);
        end
        b_res_ready = 1'b1;
        tick();
        b_res_ready = 1'b0;
    endtask

    task automatic clear_b;
        b_err_clr = 1'b1;
        tick();
        b_err_clr = 1'b0;
        m_err_b = 0;
        n_vec++;
        if (b_err_cnt !== 2'd0) begin
            n_err++;
            $display("FAIL b_clear got %0d expected 0", b_err_cnt);
        end
    endtask

    task automatic test_mismatch_saturation;
        int         seq [5] = '{1, 2, 3, 3, 3};
        logic [1:0] v;
        clear_b();
        for (int i = 0; i < 5; i++) begin
            v = 2'($urandom_range(3));
            run_vec_b(v, ~(v[0] | v[1]), 1'b0);
            n_vec++;
            if (b_err_cnt !== 2'(seq[i])) begin
                n_err++;
                $display("FAIL saturation_step_%0d got err_cnt=%0d expected %0d", i, b_err_cnt, seq[i]);
            end
        end
    endtask

    task automatic test_clear_collision;
        clear_b();
        run_vec_b(2'b01, 1'b0, 1'b0);
        run_vec_b(2'b00, 1'b1, 1'b0);
        n_vec++;
        if (b_err_cnt !== 2'd2) begin
            n_err++;
            $display("FAIL collision_setup got err_cnt=%0d expected 2", b_err_cnt);
        end
        run_vec_b(2'b10, 1'b0, 1'b1);
        n_vec++;
        if (b_err_cnt !== 2'd0) begin
            n_err++;
            $display("FAIL clear_collision got err_cnt=%0d expected 0", b_err_cnt);
        end
    endtask

    task automatic test_min_settle;
        logic [1:0] vecs [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        int         acc_cyc [4] = '{0, 0, 0, 0};
        int         res_cyc [4] = '{0, 0, 0, 0};
        logic [1:0] res_v [4];
        int         idx = 0;
        int         nres = 0;
        int         cyc = 0;
        logic       acc;
        b_res_ready = 1'b1;
        b_vec_expect = 1'b0;
        b_vec_data = vecs[0];
        b_vec_valid = 1'b1;
        while (nres < 4 && cyc < 40) begin
            acc = b_vec_valid & b_vec_ready;
            tick();
            cyc++;
            if (acc) begin
                acc_cyc[idx] = cyc;
                idx++;
                if (idx < 4) b_vec_data = vecs[idx];
                else b_vec_valid = 1'b0;
            end
            if (b_res_valid === 1'b1) begin
                res_cyc[nres] = cyc;
                res_v[nres] = b_res_vec;
                nres++;
            end
        end
        b_vec_valid = 1'b0;
        b_res_ready = 1'b0;
        n_vec++;
        if (nres != 4) begin
            n_err++;
            $display("FAIL min_settle_timeout got %0d results expected 4", nres);
        end
        for (int i = 0; i < nres; i++) begin
            n_vec++;
            if (res_cyc[i] != acc_cyc[i] + SB || res_v[i] !== vecs[i]) begin
                n_err++;
                $display("FAIL min_settle_result_%0d got cyc=%0d vec=%b expected cyc=%0d vec=%b",
                         i, res_cyc[i], res_v[i], acc_cyc[i] + SB, vecs[i]);
            end
            if (i > 0) begin
                n_vec++;
                if (acc_cyc[i] - acc_cyc[i-1] != SB + 2) begin
                    n_err++;
                    $display("FAIL min_settle_spacing_%0d got %0d expected %0d",
                             i, acc_cyc[i] - acc_cyc[i-1], SB + 2);
                end
            end
        end
    endtask

    task automatic test_mid_reset;
        logic [1:0] v;
        v = 2'($urandom_range(3, 1));
        a_vec_data = v; a_vec_expect = 1'b0; a_vec_valid = 1'b1;
        tick();
        a_vec_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({a_drive_in1, a_drive_in2, a_res_valid, a_err_cnt} !== 11'b0) begin
            n_err++;
            $display("FAIL mid_reset_async got drv=%b%b valid=%b err=%0d expected 00 0 0",
                     a_drive_in2, a_drive_in1, a_res_valid, a_err_cnt);
        end
        #2 rst_n = 1'b1;
        m_err_a = 0;
        m_err_b = 0;
        for (int k = 0; k < SA + 4; k++) begin
            tick();
            n_vec++;
            if (a_vec_ready !== 1'b1 || a_res_valid !== 1'b0) begin
                n_err++;
                $display("FAIL mid_reset_after_%0d got ready=%b valid=%b expected 1 0",
                         k, a_vec_ready, a_res_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_vector();
        test_back_pressure();
        test_random_a();
        test_mismatch_saturation();
        test_clear_collision();
        test_min_settle();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
